// File: rtl/xor_gate_pkg.sv
// Shared constants and helpers for the xor_gate compare/diff leaf and its siblings.
package xor_gate_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int POPCOUNT_MAX_W  = 256;

    // $clog2(w+1) can be 0 for w=0, so clamp to keep count ports at least one bit wide.
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w + 1);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int popcount(input logic [POPCOUNT_MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/xor_gate_popcount.sv
// Combinational adder-tree population count of a WIDTH-bit vector.
module xor_popcount
    import xor_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LEAVES = 1 << LEVELS;

    // Level 0 holds one leaf per bit padded with zeros to a power of two; each level halves.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [CNT_W-1:0] sum [LEAVES >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < LEAVES; i++) begin : g_n
                if (i < WIDTH) begin : g_bit
                    assign sum[i] = CNT_W'(vec[i]);
                end else begin : g_pad
                    assign sum[i] = '0;
                end
            end
        end else begin : g_add
            for (genvar i = 0; i < (LEAVES >> l); i++) begin : g_n
                assign sum[i] = g_lvl[l-1].sum[2*i] + g_lvl[l-1].sum[2*i+1];
            end
        end
    end

    assign cnt = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/xor_gate.sv
// Bitwise XOR leaf with a combinational output and a one-stage registered result
// carrying parity and difference count.
module xor_gate
    import xor_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             parity_q,
    output logic [CNT_W-1:0] diff_cnt_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] pop_cnt;
    logic [WIDTH-1:0] y_d;
    logic             parity_d;
    logic [CNT_W-1:0] diff_cnt_d;
    logic             out_valid_d;
    logic             out_valid_q;

    assign diff = a ^ b;
    assign y    = diff;

    xor_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcount (
        .vec (diff),
        .cnt (pop_cnt)
    );

    // Results load only on accepted inputs; out_valid simply follows in_valid.
    always_comb begin
        y_d         = y_q;
        parity_d    = parity_q;
        diff_cnt_d  = diff_cnt_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            y_d        = diff;
            parity_d   = ^diff;
            diff_cnt_d = pop_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q         <= '0;
            parity_q    <= 1'b0;
            diff_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            parity_q    <= parity_d;
            diff_cnt_q  <= diff_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate at WIDTH=8 and WIDTH=1 against a behavioural model.
module tb_xor_gate;

    logic       clk;
    logic       rst;

    logic [7:0] a8, b8, y8, yQ8;
    logic       par8, vIn8, vOut8;
    logic [3:0] cnt8;

    logic       a1, b1, y1, yQ1;
    logic       par1, vIn1, vOut1;
    logic [0:0] cnt1;

    int testsRun;
    int testsFailed;

    // Expected registered state, held between cycles like the outputs it predicts
    logic [7:0] expY8;
    int         expCnt8;
    logic       expPar8;
    logic       expV8;
    logic       expY1;
    logic       expV1;

    xor_gate #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .a          (a8),
        .b          (b8),
        .in_valid   (vIn8),
        .y          (y8),
        .y_q        (yQ8),
        .parity_q   (par8),
        .diff_cnt_q (cnt8),
        .out_valid  (vOut8)
    );

    xor_gate #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .a          (a1),
        .b          (b1),
        .in_valid   (vIn1),
        .y          (y1),
        .y_q        (yQ1),
        .parity_q   (par1),
        .diff_cnt_q (cnt1),
        .out_valid  (vOut1)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic v);
        a8   = av;
        b8   = bv;
        vIn8 = v;
    endtask

    task automatic checkReg8(input string tag, input logic [7:0] ey, input int ec,
                             input logic ep, input logic ev);
        checkOutput({tag, "_y_q"}, 32'(yQ8), 32'(ey));
        checkOutput({tag, "_cnt"}, 32'(cnt8), 32'(ec));
        checkOutput({tag, "_par"}, 32'(par8), 32'(ep));
        checkOutput({tag, "_vld"}, 32'(vOut8), 32'(ev));
    endtask

    logic [7:0] ra, rb;
    logic       rv, ra1, rb1, rv1;
    logic [1:0] pa;
    logic [1:0] pb;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst  = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0);
        a1 = 1'b0; b1 = 1'b0; vIn1 = 1'b0;

        // WIDTH=1 truth table on the combinational path
        pa = 2'b00; pb = 2'b00;
        for (int i = 0; i < 4; i++) begin
            pa = 2'(i >> 1);
            pb = 2'(i & 1);
            a1 = pa[0];
            b1 = pb[0];
            #10;
            checkOutput("w1_truth", 32'(y1), 32'(pa[0] != pb[0]));
        end

        // Reset held across edges keeps registered outputs at zero
        applyStimulus(8'hA5, 8'h0F, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkReg8("rst_hold", 8'h00, 0, 1'b0, 1'b0);
        checkOutput("rst_y_comb", 32'(y8), 32'h0000_00AA);

        rst = 1'b0;
        @(posedge clk);
        #1;
        checkReg8("a5_0f", 8'hAA, 4, 1'b0, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        checkReg8("hold", 8'hAA, 4, 1'b0, 1'b0);

        // Back-to-back boundary vectors: a==~b then a single differing bit
        applyStimulus(8'hFF, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        checkReg8("all_diff", 8'hFF, 8, 1'b0, 1'b1);
        applyStimulus(8'h01, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        checkReg8("one_diff", 8'h01, 1, 1'b1, 1'b1);
        applyStimulus(8'h3C, 8'h3C, 1'b1);
        @(posedge clk);
        #1;
        checkReg8("equal", 8'h00, 0, 1'b0, 1'b1);

        // Asynchronous reset between edges clears results, y unaffected
        applyStimulus(8'hF0, 8'h11, 1'b1);
        @(posedge clk);
        #1;
        checkReg8("preload", 8'hE1, 4, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkReg8("async_rst", 8'h00, 0, 1'b0, 1'b0);
        checkOutput("async_rst_y", 32'(y8), 32'h0000_00E1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        checkReg8("post_rst", 8'h00, 0, 1'b0, 1'b0);

        // Random regression on both widths
        expY8 = 8'h00; expCnt8 = 0; expPar8 = 1'b0; expV8 = 1'b0;
        expY1 = 1'b0;  expV1 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rv  = 1'($urandom_range(0, 1));
            ra1 = 1'($urandom_range(0, 1));
            rb1 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (i % 50 == 7)  rb = ra;
            if (i % 50 == 23) rb = ~ra;
            applyStimulus(ra, rb, rv);
            a1 = ra1; b1 = rb1; vIn1 = rv1;
            #1;
            checkOutput("rand_y8", 32'(y8), 32'(ra ^ rb));
            checkOutput("rand_y1", 32'(y1), 32'(ra1 != rb1));
            if (rv) begin
                expY8   = ra ^ rb;
                expCnt8 = 0;
                for (int k = 0; k < 8; k++) expCnt8 += (ra[k] == rb[k]) ? 0 : 1;
                expPar8 = (expCnt8 % 2) == 1;
            end
            expV8 = rv;
            if (rv1) expY1 = (ra1 != rb1);
            expV1 = rv1;
            @(posedge clk);
            #1;
            checkReg8("rand8", expY8, expCnt8, expPar8, expV8);
            checkOutput("rand1_y_q", 32'(yQ1), 32'(expY1));
            checkOutput("rand1_cnt", 32'(cnt1), 32'(expY1));
            checkOutput("rand1_par", 32'(par1), 32'(expY1));
            checkOutput("rand1_vld", 32'(vOut1), 32'(expV1));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
